// File: rtl/counter_pkg.sv
// Shared types and sizing for the counter sequencer: FSM state encoding,
// default counter width and the saturating wrap-counter width.
package counter_pkg;

    localparam int unsigned CounterWidth = 4;
    localparam int unsigned WrapsWidth   = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } state_e;

endpackage

// File: rtl/up_counter_core.sv
// Width-bit up counter with synchronous clear (priority) and count enable,
// asynchronous active-low reset.
module up_counter_core #(
    parameter int unsigned Width = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [Width-1:0] count_o
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + Width'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Start/stop/abort sequencer around an up counter: one-shot or auto-reload
// runs to a latched terminal count, with a done pulse and saturating wrap count.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = CounterWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  abort,
    input  logic                  auto_reload,
    input  logic [WIDTH-1:0]      terminal,
    output logic [WIDTH-1:0]      count,
    output logic                  busy,
    output logic                  done,
    output logic [WrapsWidth-1:0] wraps
);

    localparam logic [WrapsWidth-1:0] WrapsMax = '1;

    state_e                state_d, state_q;
    logic [WIDTH-1:0]      term_d, term_q;
    logic                  mode_d, mode_q;
    logic                  done_d, done_q;
    logic [WrapsWidth-1:0] wraps_d, wraps_q;
    logic                  cnt_clr, cnt_en;

    up_counter_core #(
        .Width (WIDTH)
    ) u_core (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (count)
    );

    always_comb begin
        state_d = state_q;
        term_d  = term_q;
        mode_d  = mode_q;
        wraps_d = wraps_q;
        done_d  = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (abort) begin
            state_d = StIdle;
            cnt_clr = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && !stop) begin
                        state_d = StRun;
                        term_d  = terminal;
                        mode_d  = auto_reload;
                        wraps_d = '0;
                        cnt_clr = 1'b1;
                    end
                end
                StRun: begin
                    // stop outranks the terminal edge: no done, no wrap
                    if (stop) begin
                        state_d = StHold;
                    end else if (count == term_q) begin
                        done_d = 1'b1;
                        if (mode_q) begin
                            cnt_clr = 1'b1;
                            if (wraps_q != WrapsMax) begin
                                wraps_d = wraps_q + 8'd1;
                            end
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
                StHold: begin
                    if (start && !stop) begin
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            term_q  <= '0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
            wraps_q <= '0;
        end else begin
            state_q <= state_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            wraps_q <= wraps_d;
        end
    end

    assign busy  = (state_q == StRun) || (state_q == StHold);
    assign done  = done_q;
    assign wraps = wraps_q;

endmodule
